// File: rtl/blink_pkg.sv
// Definitions shared by the LED blinker and the blink period meter.
// Both sides derive the expected blink period from blink_period_cycles().
package blink_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_ARMED   = ST_ARMED,
      S_MEASURE = ST_MEASURE
   } meter_state_t;

   localparam int BLINK_CNT_W = 24;

   // The blinker toggles led every (BLINK_HALF_STEP << (3 - speed)) clk cycles.
   localparam int unsigned BLINK_HALF_STEP = 12;

   function automatic int unsigned blink_period_cycles(input logic [1:0] speed);
      int unsigned shift;
      shift = 32'd3 - 32'(speed);
      return 2 * (BLINK_HALF_STEP << shift);
   endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Synchroniser for an asynchronous input followed by a one-flop edge detector.
// rise/fall are single-cycle strobes derived from the synchronised level.
module sig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic sig,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign level = sync_reg[SYNC_STAGES-1];
   assign rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;
   assign fall  = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// and flags loss of signal when no rising edge arrives within TIMEOUT cycles.
module blink_period_meter
   import blink_pkg::*;
#(
   parameter int          CNT_W       = BLINK_CNT_W,
   parameter int unsigned TIMEOUT     = 1000000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   logic unused_level;
   logic rise;
   logic fall;

   sig_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .sig    (sig_in),
      .level  (unused_level),
      .rise   (rise),
      .fall   (fall)
   );

   meter_state_t     state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] hi_lat_reg;
   logic [CNT_W-1:0] period_reg;
   logic [CNT_W-1:0] high_time_reg;
   logic             valid_reg;
   logic             locked_reg;
   logic             timeout_reg;

   logic load_period;
   logic load_hi;
   logic set_timeout;
   logic clr_timeout;

   always_comb begin
      state_next  = state_reg;
      load_period = 1'b0;
      load_hi     = 1'b0;
      set_timeout = 1'b0;
      clr_timeout = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (rise) begin
               clr_timeout = 1'b1;
               state_next  = S_ARMED;
            end
         end
         S_ARMED, S_MEASURE: begin
            load_hi = fall;
            // A rise arriving on the deadline cycle still counts as signal present.
            if (rise) begin
               load_period = 1'b1;
               clr_timeout = 1'b1;
               state_next  = S_MEASURE;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               set_timeout = 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         hi_lat_reg    <= '0;
         period_reg    <= '0;
         high_time_reg <= '0;
         valid_reg     <= 1'b0;
         locked_reg    <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         valid_reg <= load_period;

         if (rise)
            cnt_reg <= '0;
         else if (cnt_reg != CNT_MAX)
            cnt_reg <= cnt_reg + CNT_ONE;

         // hi_lat is deliberately kept across rises so a missed fall reports the old value.
         if (load_hi)
            hi_lat_reg <= cnt_reg + CNT_ONE;

         if (load_period) begin
            period_reg    <= cnt_reg + CNT_ONE;
            high_time_reg <= hi_lat_reg;
            locked_reg    <= 1'b1;
         end else if (set_timeout) begin
            locked_reg    <= 1'b0;
         end

         if (clr_timeout)
            timeout_reg <= 1'b0;
         else if (set_timeout)
            timeout_reg <= 1'b1;
      end
   end

   assign period       = period_reg;
   assign high_time    = high_time_reg;
   assign period_valid = valid_reg;
   assign locked       = locked_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: timestamp-based reference model checked every
// cycle, plus directed waveforms with hand-computed pulse expectations.
module tb_blink_period_meter;
   import blink_pkg::*;

   localparam int          CNT_W   = 24;
   localparam int unsigned TIMEOUT = 100;
   localparam int          SYNC    = 2;

   logic             clk    = 1'b0;
   logic             resetn = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             period_valid;
   logic             locked;
   logic             timeout;

   blink_period_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .sig_in       (sig_in),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .locked       (locked),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: works on sampled input history and rise timestamps.
   bit  hist [0:7];
   bit  have_ref;
   int  t_rise;
   int  m_period, m_high, m_hi;
   bit  m_valid, m_locked, m_timeout;
   bit  live = 1'b0;

   always @(posedge clk) begin
      bit r, f;
      cyc++;
      if (!resetn) begin
         foreach (hist[i]) hist[i] = 1'b0;
         have_ref  = 1'b0;
         t_rise    = 0;
         m_period  = 0;
         m_high    = 0;
         m_hi      = 0;
         m_valid   = 1'b0;
         m_locked  = 1'b0;
         m_timeout = 1'b0;
         live      = 1'b1;
      end else begin
         // Edge seen now reflects input sampled SYNC cycles ago vs. one before.
         r = hist[SYNC-1] & ~hist[SYNC];
         f = ~hist[SYNC-1] & hist[SYNC];
         for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = sig_in;
         m_valid = 1'b0;
         if (r) begin
            if (have_ref) begin
               m_period = cyc - t_rise;
               m_high   = m_hi;
               m_valid  = 1'b1;
               m_locked = 1'b1;
            end
            m_timeout = 1'b0;
            have_ref  = 1'b1;
            t_rise    = cyc;
         end else if (have_ref) begin
            if (f) m_hi = cyc - t_rise;
            if (cyc - t_rise == int'(TIMEOUT)) begin
               m_timeout = 1'b1;
               m_locked  = 1'b0;
               have_ref  = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         tests++;
         if ({period, high_time, period_valid, locked, timeout} !==
             {CNT_W'(m_period), CNT_W'(m_high), m_valid, m_locked, m_timeout}) begin
            fails++;
            if (fails <= 20)
               $display("FAIL model_cmp cyc=%0d: got p=%0d h=%0d v=%b l=%b t=%b, expected p=%0d h=%0d v=%b l=%b t=%b",
                        cyc, period, high_time, period_valid, locked, timeout,
                        m_period, m_high, m_valid, m_locked, m_timeout);
         end
      end
   end

   // Pulse / timeout monitor.
   typedef struct {
      int cyc;
      int p;
      int h;
      bit l;
   } pulse_t;

   pulse_t q[$];
   bit     to_prev     = 1'b0;
   int     to_fall_cyc = -1;
   int     to_seen     = 0;

   always @(negedge clk) begin
      if (live) begin
         if (period_valid === 1'b1) begin
            q.push_back('{cyc, int'(period), int'(high_time), locked});
            $display("[TB] pulse cyc=%0d period=%0d high_time=%0d locked=%b",
                     cyc, period, high_time, locked);
         end
         if (timeout === 1'b1) to_seen++;
         if (to_prev && timeout === 1'b0) to_fall_cyc = cyc;
         to_prev = (timeout === 1'b1);
      end
   end

   task automatic wave(input int hi, input int lo, input int n);
      repeat (n) begin
         sig_in = 1'b1;
         repeat (hi) @(negedge clk);
         sig_in = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      @(negedge clk);
      check("rst_period", int'(period), 0);
      check("rst_high", int'(high_time), 0);
      check("rst_valid", int'(period_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_timeout", int'(timeout), 0);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int c_t;
      int bp;

      // Reset held with the input toggling: outputs stay 0.
      resetn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset_outputs", int'({period, high_time, period_valid, locked, timeout} != '0), 0);
         sig_in = ~sig_in;
      end
      sig_in = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_outputs", int'({period, high_time, period_valid, locked, timeout} != '0), 0);
      repeat (3) @(negedge clk);

      // 20 high / 20 low, five periods.
      q.delete();
      wave(20, 20, 5);
      check("t2_pulse_count", q.size(), 4);
      if (q.size() > 0) begin
         check("t2_first_period", q[0].p, 40);
         check("t2_first_high", q[0].h, 20);
         check("t2_first_locked", int'(q[0].l), 1);
      end
      for (int i = 1; i < q.size(); i++)
         check("t2_pulse_spacing", q[i].cyc - q[i-1].cyc, 40);

      // Stop toggling: timeout exactly TIMEOUT cycles after the last rise.
      c_t = -1;
      for (int k = 0; k < 200 && c_t < 0; k++) begin
         @(negedge clk);
         if (timeout === 1'b1) c_t = cyc;
      end
      check("t4_timeout_seen", int'(c_t >= 0), 1);
      if (q.size() > 0 && c_t >= 0)
         check("t4_timeout_delay", c_t - q[q.size()-1].cyc, 100);
      check("t4_period_hold", int'(period), 40);
      check("t4_locked_drop", int'(locked), 0);

      // Resume: timeout clears on first rise, lock returns one period later.
      q.delete();
      wave(20, 20, 3);
      check("t4_timeout_cleared", int'(timeout), 0);
      check("t4_resume_pulses", q.size(), 2);
      if (q.size() > 0) begin
         check("t4_relock_delay", q[0].cyc - to_fall_cyc, 40);
         check("t4_relock_locked", int'(q[0].l), 1);
      end

      // Minimum period of 2.
      pulse_reset();
      q.delete();
      wave(1, 1, 10);
      repeat (4) @(negedge clk);
      check("t3_pulse_count", q.size(), 9);
      for (int i = 0; i < q.size(); i++) begin
         check("t3_period", q[i].p, 2);
         check("t3_high", q[i].h, 1);
         if (i > 0) check("t3_spacing", q[i].cyc - q[i-1].cyc, 2);
      end

      // Blinker loopback at speed 2.
      pulse_reset();
      q.delete();
      to_seen = 0;
      bp = int'(blink_period_cycles(2'd2));
      check("t5_blink_period_const", bp, 48);
      wave(bp / 2, bp / 2, 20);
      check("t5_pulse_count", q.size(), 19);
      for (int i = 0; i < q.size(); i++) begin
         check("t5_period", q[i].p, 48);
         check("t5_high", q[i].h, 24);
      end
      check("t5_no_timeout", to_seen, 0);

      // Reset mid-measurement: next pulse only after two new rises.
      repeat (5) @(negedge clk);
      pulse_reset();
      check("t6_post_reset_locked", int'(locked), 0);
      q.delete();
      repeat (10) @(negedge clk);
      wave(24, 24, 3);
      check("t6_pulse_count", q.size(), 2);
      if (q.size() > 0) begin
         check("t6_first_period", q[0].p, 48);
         check("t6_first_high", q[0].h, 24);
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
